stepper_ctrl_gen2: RTL and testbench

- Parametrised stepper-motor controller. Turns debounced single-cycle key pulses into run/stop, direction, speed-level and step-mode state.
- Generates the step timebase and drives the 4-phase coil pattern directly, in full-step or half-step mode.
- Keeps a signed step-position count.
- Sits between the key debouncers and the motor driver pins; LED status goes to the board LEDs.

---
 rtl/stepper_ctrl_gen2.sv | 131 +++++++++++++
 tb/tb_stepper_ctrl_gen2.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_ctrl_gen2.sv
// Stepper-motor controller: key pulses set run/dir/speed/mode; a divider times each step
// and the 4-phase coil pattern, step tick and signed position follow from it.
module stepper_ctrl_gen2 #(
    parameter int SPEED_W    = 4,
    parameter int SPEED_MIN  = 1,
    parameter int SPEED_MAX  = 15,
    parameter int SPEED_INIT = 5,
    parameter int BASE_DIV   = 50000,
    parameter int POS_W      = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               keystart,
    input  logic               keydirect,
    input  logic               keyacce,
    input  logic               keydece,
    input  logic               keymode,
    output logic               startstopsig,
    output logic               directsig,
    output logic [SPEED_W-1:0] speeddata,
    output logic               halfstep,
    output logic               step_tick,
    output logic [3:0]         coil,
    output logic [POS_W-1:0]   position,
    output logic [1:0]         ledstatus
);

    localparam int P_MAX = BASE_DIV * (SPEED_MAX + 1 - SPEED_MIN);
    localparam int DIV_W = (P_MAX > 1) ? $clog2(P_MAX) : 1;
    localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]   POS_ONE   = {{(POS_W-1){1'b0}}, 1'b1};
    localparam logic [SPEED_W-1:0] SPEED_ONE = {{(SPEED_W-1){1'b0}}, 1'b1};

    logic [DIV_W-1:0]   r_div;
    logic [2:0]         r_idx;
    logic               r_run;
    logic               r_dir;
    logic               r_half;
    logic               r_tick;
    logic [SPEED_W-1:0] r_speed;
    logic [POS_W-1:0]   r_pos;

    logic [31:0] w_period_m1;
    logic        w_hit;
    logic        w_k_start, w_k_dir, w_k_mode, w_k_acce, w_k_dece;
    logic [2:0]  w_inc;
    logic [2:0]  w_next_idx;
    logic [3:0]  w_phase;

    // Compare uses the live speed, so a speed-up past the current count fires on the next edge.
    assign w_period_m1 = 32'(BASE_DIV) * (32'(SPEED_MAX + 1) - 32'(r_speed)) - 32'd1;
    assign w_hit       = r_run && (32'(r_div) >= w_period_m1);

    assign w_k_start = keystart;
    assign w_k_dir   = keydirect & ~keystart;
    assign w_k_mode  = keymode & ~keystart & ~keydirect;
    assign w_k_acce  = keyacce & ~keystart & ~keydirect & ~keymode;
    assign w_k_dece  = keydece & ~keystart & ~keydirect & ~keymode & ~keyacce;

    assign w_inc      = r_half ? 3'd1 : 3'd2;
    assign w_next_idx = r_dir ? (r_idx - w_inc) : (r_idx + w_inc);

    always_comb begin
        w_phase = 4'b0000;
        case (r_idx)
            3'd0: w_phase = 4'b0001;
            3'd1: w_phase = 4'b0011;
            3'd2: w_phase = 4'b0010;
            3'd3: w_phase = 4'b0110;
            3'd4: w_phase = 4'b0100;
            3'd5: w_phase = 4'b1100;
            3'd6: w_phase = 4'b1000;
            3'd7: w_phase = 4'b1001;
            default: w_phase = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_div   <= '0;
            r_idx   <= 3'd1;
            r_run   <= 1'b0;
            r_dir   <= 1'b0;
            r_half  <= 1'b0;
            r_tick  <= 1'b0;
            r_speed <= SPEED_W'(SPEED_INIT);
            r_pos   <= '0;
        end else begin
            r_tick <= w_hit;
            if (w_hit) begin
                r_idx <= w_next_idx;
                r_pos <= r_dir ? (r_pos - POS_ONE) : (r_pos + POS_ONE);
            end

            if (w_k_start)
                r_run <= ~r_run;

            if (w_k_start || !r_run)
                r_div <= '0;
            else if (w_hit)
                r_div <= '0;
            else
                r_div <= r_div + DIV_ONE;

            if (w_k_dir)
                r_dir <= ~r_dir;

            // Mode change only while stopped, so it never collides with an index step.
            if (w_k_mode && !r_run) begin
                r_half <= ~r_half;
                if (r_half)
                    r_idx <= r_idx | 3'b001;
            end

            if (w_k_acce && (r_speed < SPEED_W'(SPEED_MAX)))
                r_speed <= r_speed + SPEED_ONE;
            if (w_k_dece && (r_speed > SPEED_W'(SPEED_MIN)))
                r_speed <= r_speed - SPEED_ONE;
        end
    end

    assign startstopsig = r_run;
    assign directsig    = r_dir;
    assign speeddata    = r_speed;
    assign halfstep     = r_half;
    assign step_tick    = r_tick;
    assign coil         = r_run ? w_phase : 4'b0000;
    assign position     = r_pos;
    assign ledstatus    = {r_run, r_dir};

endmodule

// File: tb/tb_stepper_ctrl_gen2.sv
// Directed bench for stepper_ctrl_gen2 with a short base divider and 8-bit position.
module tb_stepper_ctrl_gen2;

    localparam int POS_W = 8;

    logic       clk = 1'b0;
    logic       rstn;
    logic       keystart, keydirect, keyacce, keydece, keymode;
    logic       startstopsig, directsig, halfstep, step_tick;
    logic [3:0] speeddata;
    logic [3:0] coil;
    logic [POS_W-1:0] position;
    logic [1:0] ledstatus;

    int n_tests = 0;
    int n_fail  = 0;

    stepper_ctrl_gen2 #(
        .SPEED_W(4), .SPEED_MIN(1), .SPEED_MAX(15), .SPEED_INIT(5),
        .BASE_DIV(4), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .keystart(keystart), .keydirect(keydirect), .keyacce(keyacce),
        .keydece(keydece), .keymode(keymode),
        .startstopsig(startstopsig), .directsig(directsig), .speeddata(speeddata),
        .halfstep(halfstep), .step_tick(step_tick), .coil(coil),
        .position(position), .ledstatus(ledstatus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] keys;   // {start, dir, mode, acce, dece}
        logic [8:0] exp;    // {run, dir, speed, half, led}
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic [4:0] k);
        @(negedge clk);
        {keystart, keydirect, keymode, keyacce, keydece} = k;
        @(negedge clk);
        {keystart, keydirect, keymode, keyacce, keydece} = 5'b0;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step_tick && n < 500);
        if (!step_tick) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: no step_tick within %0d cycles", n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    localparam logic [4:0] K_START = 5'b10000;
    localparam logic [4:0] K_DIR   = 5'b01000;
    localparam logic [4:0] K_MODE  = 5'b00100;
    localparam logic [4:0] K_ACCE  = 5'b00010;
    localparam logic [4:0] K_DECE  = 5'b00001;

    initial begin
        int n;
        logic [POS_W-1:0] p0;
        logic seen;

        vecs[0]  = '{5'b00010, {1'b0, 1'b0, 4'd6, 1'b0, 2'b00}};
        vecs[1]  = '{5'b00001, {1'b0, 1'b0, 4'd5, 1'b0, 2'b00}};
        vecs[2]  = '{5'b00001, {1'b0, 1'b0, 4'd4, 1'b0, 2'b00}};
        vecs[3]  = '{5'b00100, {1'b0, 1'b0, 4'd4, 1'b1, 2'b00}};
        vecs[4]  = '{5'b01000, {1'b0, 1'b1, 4'd4, 1'b1, 2'b01}};
        vecs[5]  = '{5'b01001, {1'b0, 1'b0, 4'd4, 1'b1, 2'b00}};
        vecs[6]  = '{5'b00110, {1'b0, 1'b0, 4'd4, 1'b0, 2'b00}};
        vecs[7]  = '{5'b10010, {1'b1, 1'b0, 4'd4, 1'b0, 2'b10}};
        vecs[8]  = '{5'b00100, {1'b1, 1'b0, 4'd4, 1'b0, 2'b10}};
        vecs[9]  = '{5'b00010, {1'b1, 1'b0, 4'd5, 1'b0, 2'b10}};
        vecs[10] = '{5'b11000, {1'b0, 1'b0, 4'd5, 1'b0, 2'b00}};

        rstn = 1'b0;
        {keystart, keydirect, keymode, keyacce, keydece} = 5'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        chk("reset_speed", 32'(speeddata), 32'd5);
        chk("reset_coil", 32'(coil), 32'h0);
        chk("reset_pos", 32'(position), 32'd0);
        chk("reset_led", 32'(ledstatus), 32'd0);
        chk("reset_half", 32'(halfstep), 32'd0);

        // Start, first tick timing, full-step forward, then reverse.
        pulse(K_START);
        chk("start_coil", 32'(coil), 32'b0011);
        wait_tick(n);
        chk("first_tick_delay", 32'(n), 32'd44);
        chk("tick1_coil", 32'(coil), 32'b0110);
        chk("tick1_pos", 32'(position), 32'd1);
        wait_tick(n);
        chk("tick2_coil", 32'(coil), 32'b1100);
        chk("tick_period", 32'(n), 32'd44);
        wait_tick(n);
        chk("tick3_coil", 32'(coil), 32'b1001);
        wait_tick(n);
        chk("tick4_coil", 32'(coil), 32'b0011);
        chk("tick4_pos", 32'(position), 32'd4);
        pulse(K_DIR);
        wait_tick(n);
        chk("rev_coil", 32'(coil), 32'b1001);
        chk("rev_pos", 32'(position), 32'd3);

        // Speed saturation at the top, plus a stop landing on a tick edge.
        pulse(K_START);
        chk("stop_coil", 32'(coil), 32'h0);
        repeat (12) pulse(K_ACCE);
        chk("speed_max", 32'(speeddata), 32'd15);
        pulse(K_START);
        chk("restart_coil", 32'(coil), 32'b1001);
        wait_tick(n);
        chk("period_fast", 32'(n), 32'd4);
        chk("fast_coil", 32'(coil), 32'b1100);
        chk("fast_pos", 32'(position), 32'd2);
        repeat (2) @(negedge clk);
        @(negedge clk);
        keystart = 1'b1;
        @(negedge clk);
        keystart = 1'b0;
        chk("stop_on_tick_tick", 32'(step_tick), 32'd1);
        chk("stop_on_tick_run", 32'(startstopsig), 32'd0);
        chk("stop_on_tick_coil", 32'(coil), 32'h0);
        chk("stop_on_tick_pos", 32'(position), 32'd1);
        pulse(K_START);
        chk("idx_retained_coil", 32'(coil), 32'b0110);
        pulse(K_START);
        repeat (20) pulse(K_DECE);
        chk("speed_min", 32'(speeddata), 32'd1);
        pulse(K_START);
        wait_tick(n);
        chk("period_slow", 32'(n), 32'd60);
        chk("slow_coil", 32'(coil), 32'b0011);
        chk("slow_pos", 32'(position), 32'd0);

        // Key table: priority and state updates from a fresh reset.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            pulse(vecs[i].keys);
            chk($sformatf("vec%0d", i),
                32'({startstopsig, directsig, speeddata, halfstep, ledstatus}),
                32'(vecs[i].exp));
        end

        // Mode changes: refused while running, half-step walk, odd-index forcing.
        do_reset();
        pulse(K_START);
        pulse(K_MODE);
        chk("mode_running", 32'(halfstep), 32'd0);
        pulse(K_START);
        pulse(K_MODE);
        chk("mode_stopped", 32'(halfstep), 32'd1);
        pulse(K_START);
        wait_tick(n);
        chk("half1_coil", 32'(coil), 32'b0010);
        wait_tick(n);
        chk("half2_coil", 32'(coil), 32'b0110);
        wait_tick(n);
        chk("half3_coil", 32'(coil), 32'b0100);
        pulse(K_START);
        pulse(K_MODE);
        chk("mode_full", 32'(halfstep), 32'd0);
        pulse(K_START);
        chk("forced_odd_coil", 32'(coil), 32'b1100);
        wait_tick(n);
        chk("full_after_half_coil", 32'(coil), 32'b1001);

        // Position wrap in reverse.
        do_reset();
        repeat (10) pulse(K_ACCE);
        pulse(K_DIR);
        pulse(K_START);
        wait_tick(n);
        chk("wrap_first", 32'(position), 32'hFF);
        for (int i = 1; i < (1 << POS_W); i++) wait_tick(n);
        chk("wrap_zero", 32'(position), 32'd0);

        // Reset asserted mid-interval.
        do_reset();
        pulse(K_START);
        repeat (10) @(negedge clk);
        p0 = position;
        rstn = 1'b0;
        #1;
        chk("arst_led", 32'(ledstatus), 32'd0);
        chk("arst_coil", 32'(coil), 32'h0);
        chk("arst_speed", 32'(speeddata), 32'd5);
        chk("arst_pos", 32'(position), 32'd0);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | step_tick;
        end
        chk("arst_no_tick", 32'(seen), 32'd0);
        rstn = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
